// File: rtl/fetch_pc_gen.sv
// ============================================================================
//  Module   : fetch_pc_gen
//  Purpose  : Fetch PC generator; drives program-memory address and the
//             c1 sidebands (pc, valid, error flags) aligned with instr_reg_c1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid_c0,
  input  logic [31:0] redirect_pc_c0,
  input  logic        halt_c0,
  input  logic        stall_c1,
  output logic [31:0] pc_read_c0,
  output logic [31:0] pc_c1,
  output logic        valid_c1,
  output logic        misalign_c1,
  output logic        range_err_c1,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);
  localparam logic [31:0] c_pc_step   = 32'd4;

  logic [31:0] r_pc_reg;
  logic [31:0] r_pc_c1;
  logic        r_valid_c1;
  logic        r_misalign_c1;
  logic        r_range_err_c1;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_addr;
  logic [31:0] w_redirect_addr;
  logic        w_range_err;

  assign w_redirect_addr = {redirect_pc_c0[31:2], 2'b00};

  // Stall re-reads the held word so the memory's registered output is unchanged.
  always_comb begin
    w_addr = r_pc_reg;
    if (reset)
      w_addr = RESET_PC;
    else if (redirect_valid_c0)
      w_addr = w_redirect_addr;
    else if (halt_c0)
      w_addr = r_pc_reg;
    else if (stall_c1)
      w_addr = r_pc_c1;
  end

  assign w_range_err = ({2'b00, w_addr[31:2]} >= c_mem_words);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_reg       <= RESET_PC;
      r_pc_c1        <= RESET_PC;
      r_valid_c1     <= 1'b0;
      r_misalign_c1  <= 1'b0;
      r_range_err_c1 <= 1'b0;
      r_fetch_cnt    <= 32'd0;
    end else begin
      r_pc_c1        <= w_addr;
      r_range_err_c1 <= w_range_err;
      r_misalign_c1  <= 1'b0;
      if (redirect_valid_c0) begin
        r_pc_reg      <= w_redirect_addr + c_pc_step;
        r_valid_c1    <= 1'b1;
        r_misalign_c1 <= |redirect_pc_c0[1:0];
        r_fetch_cnt   <= r_fetch_cnt + 32'd1;
      end else if (halt_c0) begin
        r_valid_c1    <= 1'b0;
      end else if (!stall_c1) begin
        r_pc_reg      <= r_pc_reg + c_pc_step;
        r_valid_c1    <= 1'b1;
        r_fetch_cnt   <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign pc_read_c0   = w_addr;
  assign pc_c1        = r_pc_c1;
  assign valid_c1     = r_valid_c1;
  assign misalign_c1  = r_misalign_c1;
  assign range_err_c1 = r_range_err_c1;
  assign fetch_cnt    = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ============================================================================
//  Module   : tb_fetch_pc_gen
//  Purpose  : Directed plus randomized checking of fetch_pc_gen against a
//             behavioural fetch model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_WORDS = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid_c0;
  logic [31:0] redirect_pc_c0;
  logic        halt_c0;
  logic        stall_c1;
  logic [31:0] pc_read_c0;
  logic [31:0] pc_c1;
  logic        valid_c1;
  logic        misalign_c1;
  logic        range_err_c1;
  logic [31:0] fetch_cnt;

  fetch_pc_gen #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid_c0(redirect_valid_c0), .redirect_pc_c0(redirect_pc_c0),
    .halt_c0(halt_c0), .stall_c1(stall_c1),
    .pc_read_c0(pc_read_c0), .pc_c1(pc_c1), .valid_c1(valid_c1),
    .misalign_c1(misalign_c1), .range_err_c1(range_err_c1), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: next word to fetch, word on decode, and sidebands.
  logic [31:0] m_next, m_held, m_cnt;
  logic        m_valid, m_mis, m_rerr;
  logic [31:0] last_read;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fetch_addr(input logic rst, input logic rd,
                                             input logic [31:0] rpc,
                                             input logic h, input logic s);
    if (rst)      return RESET_PC;
    else if (rd)  return rpc & 32'hFFFF_FFFC;
    else if (h)   return m_next;
    else if (s)   return m_held;
    else          return m_next;
  endfunction

  // One clock: drive, check combinational address, clock, check registered state.
  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc,
                      input logic h, input logic s);
    logic [31:0] a;
    reset = rst; redirect_valid_c0 = rd; redirect_pc_c0 = rpc;
    halt_c0 = h; stall_c1 = s;
    #1;
    a = fetch_addr(rst, rd, rpc, h, s);
    last_read = pc_read_c0;
    chk("pc_read_c0", pc_read_c0, a);
    @(posedge clk);
    if (rst) begin
      m_next = RESET_PC; m_held = RESET_PC; m_valid = 0;
      m_mis = 0; m_rerr = 0; m_cnt = 0;
    end else begin
      m_held = a;
      m_rerr = (a / 4) >= MEM_WORDS;
      m_mis  = rd && (rpc % 4 != 0);
      if (rd || (!h && !s)) begin
        m_next  = a + 4;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
      end else if (h) begin
        m_valid = 0;
      end
    end
    #1;
    chk("pc_c1", pc_c1, m_held);
    chk("valid_c1", {31'd0, valid_c1}, {31'd0, m_valid});
    chk("misalign_c1", {31'd0, misalign_c1}, {31'd0, m_mis});
    chk("range_err_c1", {31'd0, range_err_c1}, {31'd0, m_rerr});
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic seq();
    step(0, 0, 32'd0, 0, 0);
  endtask

  initial begin
    logic [31:0] rpc;
    int          sel;

    step(1, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 0, 0);
    chk("lit reset pc_c1", pc_c1, 32'h0);
    chk("lit reset valid", {31'd0, valid_c1}, 32'd0);
    chk("lit reset cnt", fetch_cnt, 32'd0);

    seq(); chk("lit first read", last_read, 32'h0);
    seq(); chk("lit read 4", last_read, 32'h4);
    seq(); chk("lit read 8", last_read, 32'h8);
    chk("lit cnt 3", fetch_cnt, 32'd3);
    chk("lit pc_c1 lag", pc_c1, 32'h8);
    seq(); seq();
    chk("lit pc_c1 0x10", pc_c1, 32'h10);

    step(0, 0, 32'd0, 0, 1); chk("lit stall read a", last_read, 32'h10);
    step(0, 0, 32'd0, 0, 1); chk("lit stall read b", last_read, 32'h10);
    chk("lit stall pc_c1", pc_c1, 32'h10);
    chk("lit stall cnt", fetch_cnt, 32'd5);
    seq(); chk("lit after stall", last_read, 32'h14);

    step(0, 1, 32'h200, 1, 1); chk("lit redirect read", last_read, 32'h200);
    chk("lit redirect valid", {31'd0, valid_c1}, 32'd1);
    seq(); chk("lit redirect seq", last_read, 32'h204);

    step(0, 1, 32'h103, 0, 0); chk("lit misalign read", last_read, 32'h100);
    chk("lit misalign pulse", {31'd0, misalign_c1}, 32'd1);
    seq(); chk("lit misalign next", last_read, 32'h104);
    chk("lit misalign cleared", {31'd0, misalign_c1}, 32'd0);

    step(0, 1, 32'h0001_FFFC, 0, 0);
    chk("lit range ok", {31'd0, range_err_c1}, 32'd0);
    seq(); chk("lit range read", last_read, 32'h0002_0000);
    chk("lit range err", {31'd0, range_err_c1}, 32'd1);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    seq(); chk("lit wrap", last_read, 32'h0);

    step(0, 1, 32'h3C, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'd0, 1, 0);
      chk("lit halt read", last_read, 32'h40);
      chk("lit halt valid", {31'd0, valid_c1}, 32'd0);
    end
    seq(); chk("lit resume read", last_read, 32'h40);
    chk("lit resume valid", {31'd0, valid_c1}, 32'd1);
    step(0, 0, 32'd0, 1, 0);
    step(1, 0, 32'd0, 1, 0); chk("lit reset mid-halt", last_read, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       rpc = $urandom;
        1:       rpc = 32'h0001_FFF0 + 32'($urandom_range(0, 31));
        2:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 1023));
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0, rpc,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Program-counter generator and fetch sequencer that drives pc_read_c0 into the program memory stage. The program memory registers the instruction, so it appears one cycle later on instr_reg_c1. This block produces the matching pc_c1 and valid_c1 sidebands, aligned with instr_reg_c1, for the decode stage. It handles sequential fetch, branch redirect, downstream stall, halt, and address-error flagging.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
MEM_WORDS, 32768, number of 32-bit words in program memory (128*256); used for the range check.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
redirect_valid_c0  input  1  branch/jump redirect request this cycle.
redirect_pc_c0  input  32  redirect target byte address.
halt_c0  input  1  suppress fetching; no valid instruction produced next cycle.
stall_c1  input  1  decode cannot accept instr_reg_c1; hold the c1 instruction.
pc_read_c0  output  32  fetch byte address to program memory (combinational).
pc_c1  output  32  byte address of the instruction currently on instr_reg_c1 (registered).
valid_c1  output  1  instr_reg_c1 holds a real instruction (registered).
misalign_c1  output  1  one-cycle pulse: the redirect accepted last cycle had pc[1:0] != 0.
range_err_c1  output  1  one-cycle pulse: last cycle's pc_read_c0[31:2] >= MEM_WORDS.
fetch_cnt  output  32  count of fetches that set valid_c1; wraps at 2^32.

Behaviour:
- State:
  - pc_reg: next sequential address.
  - pc_c1, valid_c1, misalign_c1, range_err_c1, fetch_cnt: all registered.
- Reset (synchronous, has priority over everything):
  - pc_reg <= RESET_PC, pc_c1 <= RESET_PC, valid_c1 <= 0, misalign_c1 <= 0, range_err_c1 <= 0, fetch_cnt <= 0.
  - While reset is high, pc_read_c0 = RESET_PC.
  - Reset asserted mid-stall or mid-redirect discards that request.
- Per-cycle address select, when not in reset. Priority: redirect > halt > stall > sequential.
  - redirect_valid_c0:
    - addr = {redirect_pc_c0[31:2], 2'b00}.
    - pc_reg <= addr + 4; valid_c1 <= 1.
    - misalign_c1 <= |redirect_pc_c0[1:0].
    - Redirect overrides a simultaneous halt_c0 or stall_c1.
  - halt_c0:
    - addr = pc_reg; pc_reg holds; valid_c1 <= 0.
    - When halt is released, fetch resumes at pc_reg with no address skipped.
  - stall_c1:
    - addr = pc_c1 (re-read the same word so the program memory output is unchanged); pc_reg holds; valid_c1 holds.
  - otherwise (sequential):
    - addr = pc_reg; pc_reg <= pc_reg + 4; valid_c1 <= 1.
- Every non-reset cycle:
  - pc_read_c0 = addr; pc_c1 <= addr.
  - range_err_c1 <= (addr[31:2] >= MEM_WORDS).
  - misalign_c1 <= 0 unless a redirect is accepted.
- Latency: the address presented in cycle N appears on pc_c1, aligned with instr_reg_c1, in cycle N+1.
- Arithmetic:
  - pc increment is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
  - fetch_cnt increments by 1 in each cycle where valid_c1 is written 1. It does not increment on stall-hold, halt, or reset, and wraps at 2^32.
- Stall behaviour:
  - A stall held for K cycles yields identical pc_c1 and instr_reg_c1 for K+1 cycles.
  - A stall while valid_c1 = 0 keeps valid_c1 = 0.
- A redirect on the same cycle stall_c1 is high kills the held instruction. The next cycle presents the target with valid_c1 = 1.

Test Plan:
- Reset, then release with RESET_PC=0: pc_read_c0 = 0, 4, 8, 12 on successive cycles. pc_c1 lags by one cycle. valid_c1 = 0 on the first post-reset cycle, 1 thereafter. fetch_cnt = 3 after 3 valid fetches.
- Sequential fetch at pc_c1=0x10, stall_c1 high for 2 cycles:
  - pc_read_c0 = 0x10 twice; pc_c1 stays 0x10 for 3 cycles; valid_c1 stays 1; fetch_cnt is frozen.
  - After release, pc_read_c0 = 0x14.
- Redirect to 0x200 with stall_c1 and halt_c0 also high: pc_read_c0 = 0x200; next cycle pc_c1 = 0x200, valid_c1 = 1; following fetch is 0x204.
- Redirect to 0x103: pc_read_c0 = 0x100; next cycle misalign_c1 = 1 for exactly one cycle; next sequential fetch is 0x104.
- Redirect to 0x0001_FFFC, then sequential:
  - 0x0001_FFFC gives range_err_c1 = 0 (index 32767).
  - 0x0002_0000 gives range_err_c1 = 1 on the following cycle.
  - Redirect to 0xFFFF_FFFC then sequential wraps to 0x0000_0000.
- halt_c0 for 3 cycles from pc_reg = 0x40: pc_read_c0 = 0x40 and valid_c1 = 0 throughout. After release, 0x40 is fetched with valid_c1 = 1. Reset asserted mid-halt returns pc_read_c0 to RESET_PC.
